// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that shares one external combinational ALU between NREQ requesters.
// Two-stage pipeline (operand register -> result register), valid/ready response, owns the {ZF,SF,OF} register.
module alu_arbiter #(
    parameter  int NREQ = 2,
    parameter  int W    = 64,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    req_fun,
    input  logic [W*NREQ-1:0]    req_a,
    input  logic [W*NREQ-1:0]    req_b,
    input  logic [NREQ-1:0]      req_setcc,
    output logic [NREQ-1:0]      gnt,
    output logic [W-1:0]         alu_a,
    output logic [W-1:0]         alu_b,
    output logic [1:0]           alu_fun,
    input  logic [W-1:0]         alu_res,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [W-1:0]         rsp_valE,
    output logic [2:0]           cc,
    input  logic                 flush
);

    typedef enum logic [1:0] {
        FUN_ADD = 2'd0,
        FUN_SUB = 2'd1,
        FUN_AND = 2'd2,
        FUN_XOR = 2'd3
    } fun_e;

    // Stage 1: operands currently presented to the shared ALU.
    logic           r_s1_valid;
    logic [W-1:0]   r_s1_a;
    logic [W-1:0]   r_s1_b;
    fun_e           r_s1_fun;
    logic [IDW-1:0] r_s1_id;
    logic           r_s1_setcc;

    // Stage 2: registered response and architectural condition codes.
    logic           r_rsp_valid;
    logic [IDW-1:0] r_rsp_id;
    logic [W-1:0]   r_rsp_valE;
    logic [2:0]     r_cc;
    logic [IDW-1:0] r_ptr;

    logic           w_advance;
    logic           w_accept;
    logic           w_any;
    logic [IDW-1:0] w_winner;
    logic           w_of;
    logic [2:0]     w_cc_next;

    assign w_advance = !r_rsp_valid || rsp_ready;
    // Holding rst_n in the accept term keeps gnt low for the whole reset pulse.
    assign w_accept  = w_any && w_advance && !flush && rst_n;

    // Round-robin pick: first requester found after the last winner.
    always_comb begin : p_rr_pick
        int v_idx;
        // NOTE: every combinational output gets a default before any condition, so no latch is inferred.
        v_idx    = 0;
        w_any    = 1'b0;
        w_winner = '0;
        for (int i = 1; i <= NREQ; i++) begin
            v_idx = (int'(r_ptr) + i) % NREQ;
            if (!w_any && req[v_idx]) begin
                w_any    = 1'b1;
                w_winner = IDW'(v_idx);
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (w_accept) begin
            gnt[w_winner] = 1'b1;
        end
    end

    always_comb begin
        w_of = 1'b0;
        case (r_s1_fun)
            FUN_ADD: w_of = (r_s1_a[W-1] == r_s1_b[W-1]) && (alu_res[W-1] != r_s1_a[W-1]);
            FUN_SUB: w_of = (r_s1_a[W-1] != r_s1_b[W-1]) && (alu_res[W-1] != r_s1_b[W-1]);
            default: w_of = 1'b0;
        endcase
        w_cc_next = {(alu_res == '0), alu_res[W-1], w_of};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_fun    <= FUN_ADD;
            r_s1_id     <= '0;
            r_s1_setcc  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_valE  <= '0;
            r_cc        <= 3'b100;
            r_ptr       <= IDW'(NREQ - 1);
        end else if (flush) begin
            // Kill both stages, even under back-pressure; the pending result is dropped.
            r_s1_valid  <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else if (w_advance) begin
            // NOTE: non-blocking assignments let stage 2 capture the old stage-1 contents at this same edge.
            r_s1_valid  <= w_accept;
            r_rsp_valid <= r_s1_valid;
            if (w_accept) begin
                r_s1_a     <= req_a[int'(w_winner)*W +: W];
                r_s1_b     <= req_b[int'(w_winner)*W +: W];
                r_s1_fun   <= fun_e'(req_fun[int'(w_winner)*2 +: 2]);
                r_s1_id    <= w_winner;
                r_s1_setcc <= req_setcc[w_winner];
                r_ptr      <= w_winner;
            end
            if (r_s1_valid) begin
                r_rsp_valE <= alu_res;
                r_rsp_id   <= r_s1_id;
                if (r_s1_setcc) begin
                    r_cc <= w_cc_next;
                end
            end
        end
    end

    assign alu_a     = r_s1_a;
    assign alu_b     = r_s1_b;
    assign alu_fun   = r_s1_fun;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_valE  = r_rsp_valE;
    assign cc        = r_cc;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed steps plus a scoreboard of expected responses filled at grant time.
// The bench supplies the external combinational ALU.
module tb_alu_arbiter;

    localparam int NREQ = 2;
    localparam int W    = 64;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [2*NREQ-1:0] req_fun;
    logic [W*NREQ-1:0] req_a;
    logic [W*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_setcc;
    logic [NREQ-1:0]   gnt;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [1:0]        alu_fun;
    logic [W-1:0]      alu_res;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [0:0]        rsp_id;
    logic [W-1:0]      rsp_valE;
    logic [2:0]        cc;
    logic              flush;

    int checks   = 0;
    int failures = 0;
    int n_pop    = 0;

    typedef struct {
        int          id;
        logic [63:0] val;
        logic        setcc;
        logic [2:0]  cc;
    } sb_t;

    sb_t        sb_q[$];
    logic [2:0] model_cc = 3'b100;

    alu_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_fun   (req_fun),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_setcc (req_setcc),
        .gnt       (gnt),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_fun   (alu_fun),
        .alu_res   (alu_res),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_valE  (rsp_valE),
        .cc        (cc),
        .flush     (flush)
    );

    function automatic logic [63:0] f_res(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
        case (f)
            2'd0:    return a + b;
            2'd1:    return b - a;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [2:0] f_cc(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        logic        of;
        r  = f_res(f, a, b);
        of = 1'b0;
        if (f == 2'd0) of = (a[63] == b[63]) && (r[63] != a[63]);
        if (f == 2'd1) of = (a[63] != b[63]) && (r[63] != b[63]);
        return {(r == 64'd0), r[63], of};
    endfunction

    assign alu_res = f_res(alu_fun, alu_a, alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] f, input logic [63:0] a,
                           input logic [63:0] b, input logic s);
        req[i]          = 1'b1;
        req_fun[2*i+:2] = f;
        req_a[64*i+:64] = a;
        req_b[64*i+:64] = b;
        req_setcc[i]    = s;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: push at each grant, pop and compare at each response handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            model_cc = 3'b100;
        end else begin
            if (rsp_valid && rsp_ready && !flush) begin
                check("sb_rsp_expected", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    sb_t e;
                    e = sb_q.pop_front();
                    n_pop++;
                    check("sb_id", 64'(rsp_id), 64'(e.id));
                    check("sb_valE", rsp_valE, e.val);
                    if (e.setcc) model_cc = e.cc;
                    check("sb_cc", 64'(cc), 64'(model_cc));
                end
            end
            if (flush) begin
                sb_q.delete();
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (gnt[i]) begin
                        sb_t e;
                        e.id    = i;
                        e.val   = f_res(req_fun[2*i+:2], req_a[64*i+:64], req_b[64*i+:64]);
                        e.setcc = req_setcc[i];
                        e.cc    = f_cc(req_fun[2*i+:2], req_a[64*i+:64], req_b[64*i+:64]);
                        sb_q.push_back(e);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        req_fun   = '0;
        req_a     = '0;
        req_b     = '0;
        req_setcc = '0;
        rsp_ready = 1'b1;
        flush     = 1'b0;
        #12;
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_rsp_valE", rsp_valE, 64'd0);
        check("rst_alu_a", alu_a, 64'd0);
        check("rst_alu_b", alu_b, 64'd0);
        check("rst_alu_fun", 64'(alu_fun), 64'd0);
        check("rst_cc", 64'(cc), 64'b100);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 1: single add, latency 2.
        set_req(0, 2'd0, 64'd5, 64'd7, 1'b1);
        @(negedge clk);
        check("t1_gnt_c0", 64'(gnt), 64'b01);
        check("t1_rsp_valid_c0", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        check("t1_alu_a_c1", alu_a, 64'd5);
        check("t1_alu_b_c1", alu_b, 64'd7);
        check("t1_alu_fun_c1", 64'(alu_fun), 64'd0);
        check("t1_gnt_c1", 64'(gnt), 64'd0);
        check("t1_rsp_valid_c1", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_rsp_valid_c2", 64'(rsp_valid), 64'd1);
        check("t1_valE", rsp_valE, 64'd12);
        check("t1_id", 64'(rsp_id), 64'd0);
        check("t1_cc", 64'(cc), 64'b000);
        @(posedge clk); #1;

        // Test 2: sub to zero, then signed-overflow add, back to back.
        set_req(1, 2'd1, 64'd9, 64'd9, 1'b1);
        @(negedge clk);
        check("t2_gnt_sub", 64'(gnt), 64'b10);
        @(posedge clk); #1;
        set_req(1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        @(negedge clk);
        check("t2_gnt_add", 64'(gnt), 64'b10);
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        check("t2_sub_valid", 64'(rsp_valid), 64'd1);
        check("t2_sub_valE", rsp_valE, 64'd0);
        check("t2_sub_id", 64'(rsp_id), 64'd1);
        check("t2_sub_cc", 64'(cc), 64'b100);
        @(posedge clk); #1;
        @(negedge clk);
        check("t2_add_valE", rsp_valE, 64'h8000_0000_0000_0000);
        check("t2_add_cc", 64'(cc), 64'b011);
        @(posedge clk); #1;
        @(negedge clk);
        check("t2_idle_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;

        // Test 3: both requesters held from reset, alternating grants.
        set_req(0, 2'd0, 64'd10, 64'd20, 1'b0);
        set_req(1, 2'd3, 64'hFF, 64'h0F, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t3_rst_gnt", 64'(gnt), 64'd0);
        check("t3_rst_cc", 64'(cc), 64'b100);
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("t3_gnt", 64'(gnt), (c % 2 == 0) ? 64'b01 : 64'b10);
            if (c >= 2) begin
                check("t3_rsp_valid", 64'(rsp_valid), 64'd1);
                check("t3_rsp_id", 64'(rsp_id), 64'(c % 2));
            end else begin
                check("t3_rsp_valid_early", 64'(rsp_valid), 64'd0);
            end
            @(posedge clk); #1;
        end
        req = '0;
        idle(3);

        // Test 4: three-cycle back-pressure with two ops queued behind the stalled result.
        set_req(0, 2'd0, 64'd1, 64'd2, 1'b1);
        @(negedge clk);
        check("t4_gnt_p", 64'(gnt), 64'b01);
        @(posedge clk); #1;
        req[0] = 1'b0;
        set_req(1, 2'd1, 64'd10, 64'd3, 1'b1);
        @(negedge clk);
        check("t4_gnt_q", 64'(gnt), 64'b10);
        @(posedge clk); #1;
        req[1] = 1'b0;
        set_req(0, 2'd3, 64'hF0, 64'hFF, 1'b1);
        rsp_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t4_stall_gnt", 64'(gnt), 64'd0);
            check("t4_stall_valid", 64'(rsp_valid), 64'd1);
            check("t4_stall_valE", rsp_valE, 64'd3);
            check("t4_stall_id", 64'(rsp_id), 64'd0);
            check("t4_stall_cc", 64'(cc), 64'b000);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t4_release_gnt", 64'(gnt), 64'b01);
        check("t4_release_valE", rsp_valE, 64'd3);
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(negedge clk);
        check("t4_q_valE", rsp_valE, 64'hFFFF_FFFF_FFFF_FFF9);
        check("t4_q_id", 64'(rsp_id), 64'd1);
        check("t4_q_cc", 64'(cc), 64'b010);
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_r_valE", rsp_valE, 64'h0F);
        check("t4_r_id", 64'(rsp_id), 64'd0);
        check("t4_r_cc", 64'(cc), 64'b000);
        @(posedge clk); #1;

        // Test 5: flush a setcc op sitting in stage 1.
        set_req(1, 2'd0, 64'd0, 64'd0, 1'b1);
        @(negedge clk);
        check("t5_gnt_f", 64'(gnt), 64'b10);
        @(posedge clk); #1;
        req[1] = 1'b0;
        flush  = 1'b1;
        set_req(0, 2'd0, 64'd2, 64'd2, 1'b0);
        @(negedge clk);
        check("t5_flush_gnt", 64'(gnt), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("t5_no_rsp", 64'(rsp_valid), 64'd0);
        check("t5_cc_kept", 64'(cc), 64'b000);
        check("t5_gnt_after", 64'(gnt), 64'b01);
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(negedge clk);
        check("t5_g_pending", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_g_valid", 64'(rsp_valid), 64'd1);
        check("t5_g_valE", rsp_valE, 64'd4);
        check("t5_g_cc", 64'(cc), 64'b000);
        @(posedge clk); #1;

        // Test 6: asynchronous reset in the middle of a stream.
        set_req(0, 2'd1, 64'd1, 64'd0, 1'b1);
        set_req(1, 2'd0, 64'd1, 64'd1, 1'b1);
        @(negedge clk);
        check("t6_gnt_c0", 64'(gnt), 64'b10);
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_gnt_c1", 64'(gnt), 64'b01);
        @(posedge clk); #1;
        check("t6_pre_valid", 64'(rsp_valid), 64'd1);
        check("t6_pre_valE", rsp_valE, 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(rsp_valid), 64'd0);
        check("t6_rst_valE", rsp_valE, 64'd0);
        check("t6_rst_id", 64'(rsp_id), 64'd0);
        check("t6_rst_alu_a", alu_a, 64'd0);
        check("t6_rst_alu_fun", 64'(alu_fun), 64'd0);
        check("t6_rst_cc", 64'(cc), 64'b100);
        check("t6_rst_gnt", 64'(gnt), 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_first_gnt", 64'(gnt), 64'b01);
        check("t6_post_valid", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        req = '0;

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
            @(posedge clk);
        end
        idle(2);
        check("drain_queue_empty", 64'(sb_q.size()), 64'd0);
        check("drain_rsp_count", 64'(n_pop), 64'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
